parallel_adder_pipe: RTL

PARALLEL_ADDER_PIPE -- requirements
Module: parallel_adder_pipe

---
 rtl/parallel_adder_pipe.sv | 130 +++++++++++++
 1 files changed

// File: rtl/parallel_adder_pipe.sv
// Pipelined ripple-slice adder/subtractor with valid/ready handshake.
// The WIDTH-bit carry chain is cut into STAGES equal slices; each register
// stage resolves one slice using the carry registered by the stage before it,
// while the not-yet-added operand bits and the finished low sum bits travel
// alongside. The last stage drives s/c/v directly.
module parallel_adder_pipe #(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             c,
  output logic             v
);

  localparam int SW   = WIDTH / STAGES;  // bits resolved per stage
  localparam int LAST = STAGES - 1;

  // Pipeline state, index 0 is the stage fed from the inputs.
  logic [STAGES-1:0] vld_r;
  logic [STAGES-1:0] carry_r;
  logic [WIDTH-1:0]  sum_r [STAGES];
  logic [WIDTH-1:0]  opa_r [STAGES];
  logic [WIDTH-1:0]  opb_r [STAGES];  // already inverted for subtract
  logic              v_r;

  // Next-state values for every stage.
  logic [WIDTH-1:0]  src_a   [STAGES];
  logic [WIDTH-1:0]  src_b   [STAGES];
  logic [WIDTH-1:0]  nxt_sum [STAGES];
  logic [STAGES-1:0] src_vld;
  logic [STAGES-1:0] nxt_carry;
  logic              nxt_v;
  logic [SW:0]       slice_sum;
  logic              carry_in;
  logic              advance;

  // The whole pipe moves together: it may move whenever the output slot is
  // empty or being drained this cycle.
  assign advance   = !vld_r[LAST] || out_ready;
  assign in_ready  = advance;
  assign out_valid = vld_r[LAST];
  assign s         = sum_r[LAST];
  assign c         = carry_r[LAST];
  assign v         = v_r;

  // Slice adders: each stage adds its own slice of the operands it receives.
  always_comb begin
    // NOTE: every variable gets a value before any branch so no latch is inferred.
    slice_sum = '0;
    carry_in  = 1'b0;
    nxt_v     = 1'b0;

    // Stage 0 takes the raw inputs; subtract is a + ~b + 1 with cin ignored.
    src_a[0]   = a;
    src_b[0]   = sub ? ~b : b;
    src_vld[0] = in_valid;
    carry_in   = sub ? 1'b1 : cin;
    nxt_sum[0] = '0;
    slice_sum  = {1'b0, src_a[0][SW-1:0]} + {1'b0, src_b[0][SW-1:0]}
               + {{SW{1'b0}}, carry_in};
    nxt_sum[0][SW-1:0] = slice_sum[SW-1:0];
    nxt_carry[0]       = slice_sum[SW];

    // Later stages continue from the registered carry and partial sum.
    for (int k = 1; k < STAGES; k++) begin
      src_a[k]   = opa_r[k-1];
      src_b[k]   = opb_r[k-1];
      src_vld[k] = vld_r[k-1];
      carry_in   = carry_r[k-1];
      nxt_sum[k] = sum_r[k-1];
      slice_sum  = {1'b0, src_a[k][k*SW +: SW]} + {1'b0, src_b[k][k*SW +: SW]}
                 + {{SW{1'b0}}, carry_in};
      nxt_sum[k][k*SW +: SW] = slice_sum[SW-1:0];
      nxt_carry[k]           = slice_sum[SW];
    end

    // Signed overflow: like-signed operands producing a differently signed sum.
    nxt_v = (src_a[LAST][WIDTH-1] == src_b[LAST][WIDTH-1]) &&
            (nxt_sum[LAST][WIDTH-1] != src_a[LAST][WIDTH-1]);
  end

  // Valid chain plus sum/carry/overflow registers; data only loads with a
  // valid entry so s/c/v hold steady while out_valid is low.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_r   <= '0;
      carry_r <= '0;
      v_r     <= 1'b0;
      for (int k = 0; k < STAGES; k++) begin
        sum_r[k] <= '0;
      end
    end else if (advance) begin
      // NOTE: non-blocking updates let each stage see its neighbour's pre-edge value.
      vld_r <= src_vld;
      for (int k = 0; k < STAGES; k++) begin
        if (src_vld[k]) begin
          sum_r[k]   <= nxt_sum[k];
          carry_r[k] <= nxt_carry[k];
        end
      end
      if (src_vld[LAST]) begin
        v_r <= nxt_v;
      end
    end
  end

  // Operand carry-along registers for the slices still to be added.
  always_ff @(posedge clk) begin
    // NOTE: these are pure data qualified by vld_r, so they carry no reset.
    if (advance) begin
      for (int k = 0; k < STAGES; k++) begin
        if (src_vld[k]) begin
          opa_r[k] <= src_a[k];
          opb_r[k] <= src_b[k];
        end
      end
    end
  end

endmodule
